// File: rtl/exec_unit_sequencer.sv
// rtl/exec_unit_sequencer.sv - execute-stage unit sequencer: ALU/shifter single-cycle, multiplier/divider multi-cycle with stall and writeback strobe
// Optional feature macro: DIV_ZERO_TRAP_EN (divide-by-zero trap instead of starting the divider)
module exec_unit_sequencer #(
    parameter int MUL_LATENCY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [1:0] issue_unit,
    output logic       issue_ready,
    input  logic       divisor_zero,
    output logic       mul_start,
    output logic       div_start,
    input  logic       div_done,
    output logic       stall,
    output logic       wb_valid,
    output logic [1:0] result_sel,
    output logic       div_zero_fault
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_SHF = 2'd1;
    localparam logic [1:0] UNIT_MUL = 2'd2;
    localparam logic [1:0] UNIT_DIV = 2'd3;

    // Counter reload: MUL_LATENCY-1 so that a count of 0 in MUL_WAIT means the result lands next cycle
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_issue_ready;
    logic       r_mul_start;
    logic       r_div_start;
    logic       r_stall;
    logic       r_wb_valid;
    logic [1:0] r_result_sel;
    logic       r_div_zero_fault;

    logic       w_accept;
    assign w_accept = issue_valid && r_issue_ready;

`ifndef DIV_ZERO_TRAP_EN
    // Operand-zero flag has no effect without the trap; kept on the port for a uniform interface
    logic w_unused_divisor_zero;
    assign w_unused_divisor_zero = divisor_zero;
`endif

    // Sequencer FSM: all outputs registered, pulses default low every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_cnt            <= 4'd0;
            r_issue_ready    <= 1'b1;
            r_mul_start      <= 1'b0;
            r_div_start      <= 1'b0;
            r_stall          <= 1'b0;
            r_wb_valid       <= 1'b0;
            r_result_sel     <= 2'd0;
            r_div_zero_fault <= 1'b0;
        end else begin
            r_mul_start      <= 1'b0;
            r_div_start      <= 1'b0;
            r_wb_valid       <= 1'b0;
            r_div_zero_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (issue_unit)
                            UNIT_ALU, UNIT_SHF: begin
                                r_wb_valid   <= 1'b1;
                                r_result_sel <= issue_unit;
                            end
                            UNIT_MUL: begin
                                r_mul_start   <= 1'b1;
                                r_stall       <= 1'b1;
                                r_issue_ready <= 1'b0;
                                r_cnt         <= MUL_LOAD;
                                r_state       <= ST_MUL_WAIT;
                            end
                            default: begin
`ifdef DIV_ZERO_TRAP_EN
                                if (divisor_zero) begin
                                    r_div_zero_fault <= 1'b1;
                                end else begin
                                    r_div_start   <= 1'b1;
                                    r_stall       <= 1'b1;
                                    r_issue_ready <= 1'b0;
                                    r_state       <= ST_DIV_WAIT;
                                end
`else
                                r_div_start   <= 1'b1;
                                r_stall       <= 1'b1;
                                r_issue_ready <= 1'b0;
                                r_state       <= ST_DIV_WAIT;
`endif
                            end
                        endcase
                    end
                end
                ST_MUL_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_wb_valid    <= 1'b1;
                        r_result_sel  <= UNIT_MUL;
                        r_stall       <= 1'b0;
                        r_issue_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DIV_WAIT: begin
                    // A done seen while div_start is still high belongs to a previous operation
                    if (div_done && !r_div_start) begin
                        r_wb_valid    <= 1'b1;
                        r_result_sel  <= UNIT_DIV;
                        r_stall       <= 1'b0;
                        r_issue_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_stall       <= 1'b0;
                    r_issue_ready <= 1'b1;
                end
            endcase
        end
    end

    assign issue_ready    = r_issue_ready;
    assign mul_start      = r_mul_start;
    assign div_start      = r_div_start;
    assign stall          = r_stall;
    assign wb_valid       = r_wb_valid;
    assign result_sel     = r_result_sel;
    assign div_zero_fault = r_div_zero_fault;

endmodule

// File: tb/tb_exec_unit_sequencer.sv
// tb/tb_exec_unit_sequencer.sv - randomized check of exec_unit_sequencer (latency 3 and 1) against a timing-rule model
module tb_exec_unit_sequencer;

    localparam int NC = 3000;
    localparam int NA = NC + 40;
`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       issue_valid = 1'b0;
    logic [1:0] issue_unit = 2'd0;
    logic       divisor_zero = 1'b0;
    logic       div_done = 1'b0;

    logic       rdy [2];
    logic       ms  [2];
    logic       ds  [2];
    logic       st  [2];
    logic       wb  [2];
    logic [1:0] sel [2];
    logic       fz  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exec_unit_sequencer #(.MUL_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_unit(issue_unit),
        .issue_ready(rdy[0]), .divisor_zero(divisor_zero), .mul_start(ms[0]),
        .div_start(ds[0]), .div_done(div_done), .stall(st[0]), .wb_valid(wb[0]),
        .result_sel(sel[0]), .div_zero_fault(fz[0])
    );

    exec_unit_sequencer #(.MUL_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_unit(issue_unit),
        .issue_ready(rdy[1]), .divisor_zero(divisor_zero), .mul_start(ms[1]),
        .div_start(ds[1]), .div_done(div_done), .stall(st[1]), .wb_valid(wb[1]),
        .result_sel(sel[1]), .div_zero_fault(fz[1])
    );

    // Expected per-cycle outputs, filled in from the timing rules when an event happens
    bit       e_wb  [2][NA];
    bit [1:0] e_sel [2][NA];
    bit       e_ms  [2][NA];
    bit       e_ds  [2][NA];
    bit       e_st  [2][NA];
    bit       e_fz  [2][NA];
    bit       div_pend [2];
    int       div_n    [2];
    bit [1:0] last_sel [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? 3 : 1;
    endfunction

    task automatic chk_reset_vals(input string where);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s_rdy%0d", where, u), 32'(rdy[u]), 32'd1);
            chk($sformatf("%s_ms%0d", where, u), 32'(ms[u]), 32'd0);
            chk($sformatf("%s_ds%0d", where, u), 32'(ds[u]), 32'd0);
            chk($sformatf("%s_st%0d", where, u), 32'(st[u]), 32'd0);
            chk($sformatf("%s_wb%0d", where, u), 32'(wb[u]), 32'd0);
            chk($sformatf("%s_sel%0d", where, u), 32'(sel[u]), 32'd0);
            chk($sformatf("%s_fz%0d", where, u), 32'(fz[u]), 32'd0);
        end
    endtask

    task automatic clear_model(input int from);
        for (int u = 0; u < 2; u++) begin
            for (int c = from; c < NA; c++) begin
                e_wb[u][c] = 0; e_sel[u][c] = 0; e_ms[u][c] = 0;
                e_ds[u][c] = 0; e_st[u][c] = 0; e_fz[u][c] = 0;
            end
            div_pend[u] = 0;
            last_sel[u] = 2'd0;
        end
    endtask

    initial begin
        clear_model(0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        reset = 1'b0;

        for (int cyc = 0; cyc < NC; cyc++) begin
            // Outstanding divide keeps the pipeline stalled until its done is seen
            for (int u = 0; u < 2; u++)
                if (div_pend[u] && cyc >= div_n[u] + 1) e_st[u][cyc] = 1;

            for (int u = 0; u < 2; u++) begin
                if (e_wb[u][cyc]) last_sel[u] = e_sel[u][cyc];
                chk($sformatf("rdy%0d", u), 32'(rdy[u]), 32'(!e_st[u][cyc]));
                chk($sformatf("stall%0d", u), 32'(st[u]), 32'(e_st[u][cyc]));
                chk($sformatf("mul_start%0d", u), 32'(ms[u]), 32'(e_ms[u][cyc]));
                chk($sformatf("div_start%0d", u), 32'(ds[u]), 32'(e_ds[u][cyc]));
                chk($sformatf("wb_valid%0d", u), 32'(wb[u]), 32'(e_wb[u][cyc]));
                chk($sformatf("result_sel%0d", u), 32'(sel[u]), 32'(last_sel[u]));
                chk($sformatf("dz_fault%0d", u), 32'(fz[u]), 32'(e_fz[u][cyc]));
            end

            if (cyc > 20 && $urandom_range(0, 199) == 0) begin
                // Asynchronous reset pulse mid-cycle: outputs must clear before the next edge
                reset = 1'b1;
                issue_valid = 1'b0;
                div_done = 1'($urandom_range(0, 1));
                #1;
                chk_reset_vals("async");
                clear_model(cyc + 1);
                #1;
                reset = 1'b0;
            end else begin
                issue_valid  = ($urandom_range(0, 3) != 0);
                issue_unit   = 2'($urandom_range(0, 3));
                divisor_zero = ($urandom_range(0, 3) == 0);
                div_done     = ($urandom_range(0, 5) == 0);
                for (int u = 0; u < 2; u++) begin
                    if (div_pend[u] && div_done && cyc >= div_n[u] + 2) begin
                        e_wb[u][cyc + 1] = 1;
                        e_sel[u][cyc + 1] = 2'd3;
                        div_pend[u] = 0;
                    end
                    if (issue_valid && !e_st[u][cyc]) begin
                        case (issue_unit)
                            2'd0, 2'd1: begin
                                e_wb[u][cyc + 1] = 1;
                                e_sel[u][cyc + 1] = issue_unit;
                            end
                            2'd2: begin
                                e_ms[u][cyc + 1] = 1;
                                for (int k = 1; k <= lat_of(u); k++) e_st[u][cyc + k] = 1;
                                e_wb[u][cyc + 1 + lat_of(u)] = 1;
                                e_sel[u][cyc + 1 + lat_of(u)] = 2'd2;
                            end
                            default: begin
                                if (TRAP && divisor_zero) begin
                                    e_fz[u][cyc + 1] = 1;
                                end else begin
                                    e_ds[u][cyc + 1] = 1;
                                    div_pend[u] = 1;
                                    div_n[u] = cyc;
                                end
                            end
                        endcase
                    end
                end
            end

            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
